// File: rtl/video_uart_ctrl_bridge.sv
// video_uart_ctrl_bridge
// UART 8N1 receiver feeding a frame parser. A frame "A5 tgt addr d0 d1 d2 d3"
// (data LSB first) becomes a one-cycle write to the bar core (tgt 0x00) or to
// the rgb2gray core (tgt 0x01).
// Build option: define VIDEO_UART_BRIDGE_CHECKSUM_EN to require one trailing
// byte equal to the XOR of tgt, addr and the four data bytes.
module video_uart_ctrl_bridge #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        uart_rxd,
    output logic        avs_video_bar_core_address,
    output logic        avs_video_bar_core_write,
    output logic [31:0] avs_video_bar_core_writedata,
    output logic        avs_video_rgb2gray_core_address,
    output logic        avs_video_rgb2gray_core_write,
    output logic [31:0] avs_video_rgb2gray_core_writedata,
    output logic        frame_err
);
    localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam logic [31:0] BIT_LAST     = 32'(CLKS_PER_BIT - 1);
    localparam logic [31:0] HALF_LAST    = 32'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0] GAP_LIMIT    = 32'(16 * CLKS_PER_BIT);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`ifdef VIDEO_UART_BRIDGE_CHECKSUM_EN
    typedef enum logic [2:0] {P_SYNC, P_TGT, P_ADDR, P_DAT0, P_DAT1, P_DAT2, P_DAT3, P_CHK} p_state_t;
`else
    typedef enum logic [2:0] {P_SYNC, P_TGT, P_ADDR, P_DAT0, P_DAT1, P_DAT2, P_DAT3} p_state_t;
`endif

    logic        rst_meta, rst_n_int;
    logic        rxd_meta, rxd_sync, rxd_prev;
    rx_state_t   rx_state, rx_next;
    logic [31:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  rx_shift;
    logic        bit_done, half_done, rx_valid, rx_ferr;
    p_state_t    p_state, p_next;
    logic [31:0] gap_cnt;
    logic        gap_timeout, commit, abort;
    logic        tgt_sel, addr_bit;
    logic [23:0] data_lo;
    logic [31:0] commit_data;
`ifdef VIDEO_UART_BRIDGE_CHECKSUM_EN
    logic [7:0]  data_hi, chk_acc;
`endif

    // Reset asserts asynchronously, releases on a clock edge (2 flops).
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rst_meta  <= 1'b0;
            rst_n_int <= 1'b0;
        end else begin
            rst_meta  <= 1'b1;
            rst_n_int <= rst_meta;
        end
    end

    // Two-flop synchronizer on the serial line plus a delayed copy for edge detect.
    always_ff @(posedge sys_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    // RX state register.
    always_ff @(posedge sys_clk or negedge rst_n_int) begin
        if (!rst_n_int) rx_state <= RX_IDLE;
        else            rx_state <= rx_next;
    end

    // RX next state; a byte is reported mid stop bit, good or framing error.
    always_comb begin
        rx_next   = rx_state;
        rx_valid  = 1'b0;
        rx_ferr   = 1'b0;
        bit_done  = (bit_cnt == BIT_LAST);
        half_done = (bit_cnt == HALF_LAST);
        case (rx_state)
            RX_IDLE:  if (rxd_prev && !rxd_sync) rx_next = RX_START;
            RX_START: if (half_done) rx_next = rxd_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_done && bit_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP: begin
                if (bit_done) begin
                    rx_next  = RX_IDLE;
                    rx_valid = rxd_sync;
                    rx_ferr  = !rxd_sync;
                end
            end
            default:  rx_next = RX_IDLE;
        endcase
    end

    // Bit timing counter and shift register for the RX FSM.
    always_ff @(posedge sys_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            bit_cnt  <= '0;
            bit_idx  <= '0;
            rx_shift <= '0;
        end else begin
            if (rx_state == RX_IDLE || rx_state != rx_next || (rx_state == RX_DATA && bit_done))
                bit_cnt <= '0;
            else
                bit_cnt <= bit_cnt + 32'd1;
            if (rx_state == RX_START) begin
                bit_idx <= '0;
            end else if (rx_state == RX_DATA && bit_done) begin
                bit_idx  <= bit_idx + 3'd1;
                rx_shift <= {rxd_sync, rx_shift[7:1]};
            end
        end
    end

    // Inter-byte gap counter, idle while hunting for sync.
    always_ff @(posedge sys_clk or negedge rst_n_int) begin
        if (!rst_n_int)                          gap_cnt <= '0;
        else if (p_state == P_SYNC || rx_valid)  gap_cnt <= '0;
        else if (gap_cnt != GAP_LIMIT)           gap_cnt <= gap_cnt + 32'd1;
    end

    assign gap_timeout = (p_state != P_SYNC) && (gap_cnt == GAP_LIMIT);

    // Parser state register.
    always_ff @(posedge sys_clk or negedge rst_n_int) begin
        if (!rst_n_int) p_state <= P_SYNC;
        else            p_state <= p_next;
    end

    // Parser next state; an 0xA5 past the sync byte is ordinary payload.
    always_comb begin
        p_next = p_state;
        commit = 1'b0;
        abort  = 1'b0;
        if (rx_ferr || gap_timeout) begin
            abort  = 1'b1;
            p_next = P_SYNC;
        end else if (rx_valid) begin
            case (p_state)
                P_SYNC: if (rx_shift == 8'hA5) p_next = P_TGT;
                P_TGT: begin
                    if (rx_shift == 8'h00 || rx_shift == 8'h01) p_next = P_ADDR;
                    else begin
                        abort  = 1'b1;
                        p_next = P_SYNC;
                    end
                end
                P_ADDR: p_next = P_DAT0;
                P_DAT0: p_next = P_DAT1;
                P_DAT1: p_next = P_DAT2;
                P_DAT2: p_next = P_DAT3;
`ifdef VIDEO_UART_BRIDGE_CHECKSUM_EN
                P_DAT3: p_next = P_CHK;
                P_CHK: begin
                    p_next = P_SYNC;
                    if (rx_shift == chk_acc) commit = 1'b1;
                    else                     abort  = 1'b1;
                end
`else
                P_DAT3: begin
                    commit = 1'b1;
                    p_next = P_SYNC;
                end
`endif
                default: p_next = P_SYNC;
            endcase
        end
    end

    // Capture frame fields as their bytes arrive.
    always_ff @(posedge sys_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            tgt_sel  <= 1'b0;
            addr_bit <= 1'b0;
            data_lo  <= '0;
`ifdef VIDEO_UART_BRIDGE_CHECKSUM_EN
            data_hi  <= '0;
            chk_acc  <= '0;
`endif
        end else if (rx_valid) begin
            case (p_state)
                P_TGT:  tgt_sel        <= rx_shift[0];
                P_ADDR: addr_bit       <= rx_shift[0];
                P_DAT0: data_lo[7:0]   <= rx_shift;
                P_DAT1: data_lo[15:8]  <= rx_shift;
                P_DAT2: data_lo[23:16] <= rx_shift;
`ifdef VIDEO_UART_BRIDGE_CHECKSUM_EN
                P_DAT3: data_hi        <= rx_shift;
`endif
                default: ;
            endcase
`ifdef VIDEO_UART_BRIDGE_CHECKSUM_EN
            if (p_state == P_TGT) chk_acc <= rx_shift;
            else                  chk_acc <= chk_acc ^ rx_shift;
`endif
        end
    end

`ifdef VIDEO_UART_BRIDGE_CHECKSUM_EN
    assign commit_data = {data_hi, data_lo};
`else
    assign commit_data = {rx_shift, data_lo};
`endif

    // Write strobes, held address/data per core, and the sticky error flag.
    always_ff @(posedge sys_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            avs_video_bar_core_address        <= 1'b0;
            avs_video_bar_core_write          <= 1'b0;
            avs_video_bar_core_writedata      <= '0;
            avs_video_rgb2gray_core_address   <= 1'b0;
            avs_video_rgb2gray_core_write     <= 1'b0;
            avs_video_rgb2gray_core_writedata <= '0;
            frame_err                         <= 1'b0;
        end else begin
            avs_video_bar_core_write      <= 1'b0;
            avs_video_rgb2gray_core_write <= 1'b0;
            if (commit) begin
                if (tgt_sel) begin
                    avs_video_rgb2gray_core_write     <= 1'b1;
                    avs_video_rgb2gray_core_address   <= addr_bit;
                    avs_video_rgb2gray_core_writedata <= commit_data;
                end else begin
                    avs_video_bar_core_write     <= 1'b1;
                    avs_video_bar_core_address   <= addr_bit;
                    avs_video_bar_core_writedata <= commit_data;
                end
                frame_err <= 1'b0;
            end else if (abort) begin
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/video_uart_ctrl_bridge.md
VIDEO_UART_CTRL_BRIDGE -- requirements
Module: video_uart_ctrl_bridge

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, meaning sys_clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD, integer division.
REQ-003 SHALL have port sys_clk, input, 1 bit: the only clock.
REQ-004 SHALL have port sys_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port uart_rxd, input, 1 bit: serial 8N1 data, LSB first, idle high.
REQ-006 SHALL have port avs_video_bar_core_address, output, 1 bit: bar core register address.
REQ-007 SHALL have port avs_video_bar_core_write, output, 1 bit: one-cycle write strobe.
REQ-008 SHALL have port avs_video_bar_core_writedata, output, 32 bits: write data.
REQ-009 SHALL have port avs_video_rgb2gray_core_address, output, 1 bit: rgb2gray core register address.
REQ-010 SHALL have port avs_video_rgb2gray_core_write, output, 1 bit: one-cycle write strobe.
REQ-011 SHALL have port avs_video_rgb2gray_core_writedata, output, 32 bits: write data.
REQ-012 SHALL have port frame_err, output, 1 bit: sticky error flag, cleared by the next good frame.

Function
REQ-013 SHALL pass uart_rxd through a 2-flop synchronizer; the synchronizer resets to 1.
REQ-014 RX FSM SHALL have states IDLE, START, DATA, STOP.
- IDLE->START on a synchronized falling edge.
- START samples at CLKS_PER_BIT/2: low->DATA; high->IDLE, treated as a glitch with no error.
- DATA samples 8 bits, one every CLKS_PER_BIT.
- STOP samples once: high gives rx_valid for one cycle; low gives a framing error and the byte is discarded.
REQ-015 Frame format SHALL be:
- 0xA5 sync, then target byte (0x00=bar, 0x01=rgb2gray), then addr byte (bit0 used), then 4 data bytes, LSB first.
REQ-016 Parser FSM SHALL have states SYNC, TGT, ADDR, DAT0-DAT3, plus CHK when the checksum feature is enabled.
- SYNC ignores all bytes other than 0xA5.
REQ-017 The parser SHALL abort to SYNC and set frame_err on any of:
- a target byte other than 0x00 or 0x01;
- a framing error;
- an inter-byte gap longer than 16*CLKS_PER_BIT sys_clk cycles while not in SYNC.
REQ-018 On frame completion, the selected write SHALL be high for exactly 1 cycle, the cycle after the last byte's rx_valid.
- address and writedata are held stable from that cycle until the next write.
- frame_err clears in the same cycle.
REQ-019 The two cores' write strobes SHALL never be asserted simultaneously.
REQ-020 A 0xA5 byte arriving mid-frame SHALL be treated as data, not as a resync.
REQ-021 Partial frame state SHALL be lost on reset; no write SHALL be issued for an interrupted frame.

Reset
REQ-022 On sys_rst_n low, both FSMs SHALL go to IDLE/SYNC and counters SHALL clear, asynchronously.
REQ-023 On sys_rst_n low, all address/write/writedata outputs SHALL be 0 and frame_err SHALL be 0.
REQ-024 Reset release SHALL be synchronous to sys_clk; the first frame is accepted after 2 cycles.

Configuration
REQ-025 With macro VIDEO_UART_BRIDGE_CHECKSUM_EN defined:
- one extra byte is required after DAT3, equal to the XOR of target, addr, and the 4 data bytes;
- on mismatch, no write is issued, frame_err is set, and the parser returns to SYNC.
REQ-026 Without the macro, no checksum byte is expected, and the write is issued after DAT3.

Verification
REQ-027 Bench SHALL run CLK_FREQ=50000000, BAUD=115200 (CLKS_PER_BIT=434) and cover these scenarios:
- A5 00 01 78 56 34 12 -> bar write=1 for 1 cycle, address=1, writedata=0x12345678; rgb2gray write stays 0.
- A5 01 00 01 00 00 00 -> rgb2gray write pulse, address=0, writedata=0x00000001; frame_err=0.
- A5 02 ... -> no write, frame_err=1; then a valid frame -> write pulse and frame_err=0.
- Valid frame with the stop bit of DAT1 forced low -> no write, frame_err=1.
- Gap of 7000 cycles after TGT, then remaining bytes -> no write, frame_err=1.
- sys_rst_n pulsed low during DAT2 -> outputs 0 immediately; the next complete frame is written correctly.
- With the macro, a checksum of 0x00 on a frame whose correct checksum is 0x5B -> no write, frame_err=1.
